// File: rtl/io_input_port.sv
// io_input_port
//   Memory-mapped KEY/SW input peripheral for the single-cycle processor.
//   Each pin group passes through a 2-flop synchronizer and a steady-count
//   debouncer. The debounced values are readable as data registers. Each
//   group also has a sticky control/status register (ready, overrun, ie).
//   Reads are purely combinational so they fit the single-cycle load path.
//
//   Optional feature macro: IO_INPUT_IRQ_EN
//     defined   : the ie bits are writable and irq is a registered OR of
//                 ready & ie over both groups.
//     undefined : irq is tied low, ie bits read 0, writes to bit8 are ignored.
//
//   DEBOUNCE_CYCLES must be >= 2.

module io_input_port #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
  parameter int               DEBOUNCE_CYCLES = 10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrData,
  output logic [DBITS-1:0] rdData,
  output logic             addrHit,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic             irq
);

  // Counter just wide enough to hold DEBOUNCE_CYCLES-1; it saturates there.
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Keys are active-low, so "all released" is the idle value.
  localparam logic [3:0] KEY_RST = 4'hF;
  localparam logic [9:0] SW_RST  = 10'h000;

  // Sticky status bits plus the interrupt enable of one pin group.
  typedef struct packed {
    logic ie;
    logic ovr;
    logic ready;
  } ctrl_t;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic hit_key;
  logic hit_sw;
  logic hit_kctrl;
  logic hit_sctrl;

  assign hit_key   = (addr == ADDR_KEY);
  assign hit_sw    = (addr == ADDR_SW);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign hit_sctrl = (addr == ADDR_SCTRL);

  // Only bits 0, 2 and 8 of a store are meaningful; the rest are dropped.
  logic unused_wrdata;
  assign unused_wrdata = ^wrData;

  // ------------------------------------------------------------------
  // KEY synchronizer and debouncer
  // ------------------------------------------------------------------
  logic [3:0]       key_sync1_q, key_sync1_d;
  logic [3:0]       key_sync2_q, key_sync2_d;
  logic [3:0]       key_prev_q, key_prev_d;
  logic [3:0]       key_stable_q, key_stable_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic             key_change;

  // KEY next state: restart the count on any input change, publish once steady.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    key_sync1_d  = KEY;
    key_sync2_d  = key_sync1_q;
    key_prev_d   = key_prev_q;
    key_cnt_d    = key_cnt_q;
    key_stable_d = key_stable_q;
    key_change   = 1'b0;

    if (key_sync2_q != key_prev_q) begin
      key_prev_d = key_sync2_q;
      key_cnt_d  = '0;
    end else if (key_cnt_q != CNT_MAX) begin
      key_cnt_d = key_cnt_q + CNT_ONE;
    end

    if ((key_cnt_q == CNT_MAX) && (key_prev_q != key_stable_q)) begin
      key_stable_d = key_prev_q;
      key_change   = 1'b1;
    end
  end

  // KEY state registers; reset aborts any count in progress.
  always_ff @(posedge clk) begin
    // NOTE: clocked blocks use non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    if (reset) begin
      key_sync1_q  <= KEY_RST;
      key_sync2_q  <= KEY_RST;
      key_prev_q   <= KEY_RST;
      key_stable_q <= KEY_RST;
      key_cnt_q    <= '0;
    end else begin
      key_sync1_q  <= key_sync1_d;
      key_sync2_q  <= key_sync2_d;
      key_prev_q   <= key_prev_d;
      key_stable_q <= key_stable_d;
      key_cnt_q    <= key_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // SW synchronizer and debouncer
  // ------------------------------------------------------------------
  logic [9:0]       sw_sync1_q, sw_sync1_d;
  logic [9:0]       sw_sync2_q, sw_sync2_d;
  logic [9:0]       sw_prev_q, sw_prev_d;
  logic [9:0]       sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic             sw_change;

  // SW next state: same rules as the KEY group.
  always_comb begin
    sw_sync1_d  = SW;
    sw_sync2_d  = sw_sync1_q;
    sw_prev_d   = sw_prev_q;
    sw_cnt_d    = sw_cnt_q;
    sw_stable_d = sw_stable_q;
    sw_change   = 1'b0;

    if (sw_sync2_q != sw_prev_q) begin
      sw_prev_d = sw_sync2_q;
      sw_cnt_d  = '0;
    end else if (sw_cnt_q != CNT_MAX) begin
      sw_cnt_d = sw_cnt_q + CNT_ONE;
    end

    if ((sw_cnt_q == CNT_MAX) && (sw_prev_q != sw_stable_q)) begin
      sw_stable_d = sw_prev_q;
      sw_change   = 1'b1;
    end
  end

  // SW state registers; a nonzero SW at reset release debounces in normally.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1_q  <= SW_RST;
      sw_sync2_q  <= SW_RST;
      sw_prev_q   <= SW_RST;
      sw_stable_q <= SW_RST;
      sw_cnt_q    <= '0;
    end else begin
      sw_sync1_q  <= sw_sync1_d;
      sw_sync2_q  <= sw_sync2_d;
      sw_prev_q   <= sw_prev_d;
      sw_stable_q <= sw_stable_d;
      sw_cnt_q    <= sw_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Control/status registers
  // ------------------------------------------------------------------
  // A change event always wins on ready. A clear of ready in the same cycle
  // consumes the previous event, so that event does not count as an overrun.
  function automatic ctrl_t ctrl_next(input ctrl_t cur, input logic change,
                                      input logic wr, input ctrl_t wr_val);
    ctrl_t nxt;
    logic  clr_ready;
    logic  clr_ovr;
    nxt       = cur;
    clr_ready = wr && !wr_val.ready;
    clr_ovr   = wr && !wr_val.ovr;

    if (change) begin
      nxt.ready = 1'b1;
    end else if (clr_ready) begin
      nxt.ready = 1'b0;
    end

    if (change && cur.ready && !clr_ready) begin
      nxt.ovr = 1'b1;
    end else if (clr_ovr) begin
      nxt.ovr = 1'b0;
    end

    if (wr) begin
      nxt.ie = wr_val.ie;
    end
    return nxt;
  endfunction

  ctrl_t wr_val;
  ctrl_t kctrl_q, kctrl_d;
  ctrl_t sctrl_q, sctrl_d;
  logic  kctrl_wr;
  logic  sctrl_wr;

  assign kctrl_wr = wrEn && hit_kctrl;
  assign sctrl_wr = wrEn && hit_sctrl;

  // Store data mapped onto the control fields; ie is forced low when disabled,
  // which keeps the ie flops at their reset value of 0.
  always_comb begin
    wr_val.ready = wrData[0];
    wr_val.ovr   = wrData[2];
`ifdef IO_INPUT_IRQ_EN
    wr_val.ie    = wrData[8];
`else
    wr_val.ie    = 1'b0;
`endif
  end

  // Control next state for both groups.
  always_comb begin
    kctrl_d = ctrl_next(kctrl_q, key_change, kctrl_wr, wr_val);
    sctrl_d = ctrl_next(sctrl_q, sw_change, sctrl_wr, wr_val);
  end

  // Control registers; all bits clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      kctrl_q <= '0;
      sctrl_q <= '0;
    end else begin
      kctrl_q <= kctrl_d;
      sctrl_q <= sctrl_d;
    end
  end

  // ------------------------------------------------------------------
  // Interrupt
  // ------------------------------------------------------------------
`ifdef IO_INPUT_IRQ_EN
  logic irq_q, irq_d;

  // Request when any group is ready with its interrupt enabled.
  always_comb begin
    irq_d = (kctrl_q.ready & kctrl_q.ie) | (sctrl_q.ready & sctrl_q.ie);
  end

  // Registered so irq follows the causing state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Read mux
  // ------------------------------------------------------------------
  // Combinational read of the addressed register; unmapped reads return 0.
  always_comb begin
    rdData  = '0;
    addrHit = 1'b0;
    if (hit_key) begin
      addrHit     = 1'b1;
      rdData[3:0] = ~key_stable_q;
    end else if (hit_sw) begin
      addrHit     = 1'b1;
      rdData[9:0] = sw_stable_q;
    end else if (hit_kctrl) begin
      addrHit   = 1'b1;
      rdData[0] = kctrl_q.ready;
      rdData[2] = kctrl_q.ovr;
      rdData[8] = kctrl_q.ie;
    end else if (hit_sctrl) begin
      addrHit   = 1'b1;
      rdData[0] = sctrl_q.ready;
      rdData[2] = sctrl_q.ovr;
      rdData[8] = sctrl_q.ie;
    end
  end

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port
//   Self-checking bench for io_input_port with DEBOUNCE_CYCLES=4.
//   Hand-written sequences cover the spec'd corner cases with constant
//   expectations; a randomized phase compares every register and irq against
//   a sample-window reference model.
`timescale 1ns/1ps

module tb_io_input_port;

  localparam int D  = 4;
  localparam int HL = D + 3;   // samples of pin history the model keeps

  localparam logic [31:0] A_KEY   = 32'hF0000010;
  localparam logic [31:0] A_SW    = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;

`ifdef IO_INPUT_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wrEn;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        addrHit;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic        irq;

  io_input_port #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .wrEn    (wrEn),
    .addr    (addr),
    .wrData  (wrData),
    .rdData  (rdData),
    .addrHit (addrHit),
    .KEY     (KEY),
    .SW      (SW),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Pin history, index 0 = sample taken at the most recent edge. A group's
  // debounced value becomes the sample from 3 edges ago once the D samples
  // ending there are identical and differ from the current value.
  typedef struct {
    bit ready;
    bit ovr;
    bit ie;
  } ctrl_t;

  logic [HL-1:0][9:0] key_hist;
  logic [HL-1:0][9:0] sw_hist;
  logic [3:0]         m_key;
  logic [9:0]         m_sw;
  ctrl_t              m_kc;
  ctrl_t              m_sc;
  bit                 m_irq;

  function automatic bit settled(input logic [HL-1:0][9:0] h, input logic [9:0] cur);
    for (int i = 3; i < HL; i++) if (h[i] !== h[3]) return 1'b0;
    return h[3] !== cur;
  endfunction

  function automatic ctrl_t ctrl_next(input ctrl_t c, input bit ev, input bit wr, input logic [31:0] d);
    ctrl_t n = c;
    bit cleared = wr && (d[0] == 1'b0);
    if (wr && d[2] == 1'b0) n.ovr = 1'b0;
    if (cleared) n.ready = 1'b0;
    if (ev) begin
      if (c.ready && !cleared) n.ovr = 1'b1;
      n.ready = 1'b1;
    end
    if (wr && IRQ_ON) n.ie = d[8];
    return n;
  endfunction

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {23'b0, c.ie, 5'b0, c.ovr, 1'b0, c.ready};
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] rd, output logic hit);
    hit = 1'b1;
    rd  = 32'h0;
    if (a == A_KEY) rd = {28'b0, ~m_key};
    else if (a == A_SW) rd = {22'b0, m_sw};
    else if (a == A_KCTRL) rd = ctrl_word(m_kc);
    else if (a == A_SCTRL) rd = ctrl_word(m_sc);
    else hit = 1'b0;
  endfunction

  // Advance the model by one edge using the inputs the DUT is about to sample.
  task automatic model_step();
    bit ek;
    bit es;
    bit irq_next;
    if (reset) begin
      key_hist = {HL{10'h00F}};
      sw_hist  = {HL{10'h000}};
      m_key    = 4'hF;
      m_sw     = 10'h0;
      m_kc     = '{1'b0, 1'b0, 1'b0};
      m_sc     = '{1'b0, 1'b0, 1'b0};
      m_irq    = 1'b0;
      return;
    end
    irq_next = (m_kc.ready && m_kc.ie) || (m_sc.ready && m_sc.ie);
    key_hist = {key_hist[HL-2:0], {6'b0, KEY}};
    sw_hist  = {sw_hist[HL-2:0], SW};
    ek = settled(key_hist, {6'b0, m_key});
    es = settled(sw_hist, m_sw);
    if (ek) m_key = key_hist[3][3:0];
    if (es) m_sw = sw_hist[3];
    m_kc  = ctrl_next(m_kc, ek, wrEn && (addr == A_KCTRL), wrData);
    m_sc  = ctrl_next(m_sc, es, wrEn && (addr == A_SCTRL), wrData);
    m_irq = irq_next;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    wrEn = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wrEn   = 1'b1;
    addr   = a;
    wrData = d;
    tick();
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    wrEn = 1'b0;
    addr = a;
    #1;
    check(name, rdData, exp);
  endtask

  // Compare all registers, one odd address and irq against the model.
  task automatic probe(input string tag);
    logic [31:0] a;
    logic [31:0] er;
    logic        eh;
    wrEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: a = A_KEY;
        1: a = A_SW;
        2: a = A_KCTRL;
        3: a = A_SCTRL;
        default: begin
          case ($urandom_range(0, 3))
            0: a = A_KEY + 32'($urandom_range(1, 3));
            1: a = 32'hF0000018;
            2: a = A_KCTRL ^ (32'h1 << $urandom_range(0, 31));
            default: a = $urandom;
          endcase
        end
      endcase
      addr = a;
      #1;
      model_read(a, er, eh);
      check($sformatf("%s rd@%08h", tag, a), rdData, er);
      check($sformatf("%s hit@%08h", tag, a), 32'(addrHit), 32'(eh));
    end
    check($sformatf("%s irq", tag), 32'(irq), 32'(m_irq));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } rd_vec_t;

  rd_vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int key_hold = 0;
    int sw_hold  = 0;

    reset = 1'b1; wrEn = 1'b0; addr = 32'h0; wrData = 32'h0;
    KEY = 4'hF; SW = 10'h0;

    // Test 1: reset state and decode table.
    vecs[0] = '{A_KEY,        32'h0, 1'b1};
    vecs[1] = '{A_SW,         32'h0, 1'b1};
    vecs[2] = '{A_KCTRL,      32'h0, 1'b1};
    vecs[3] = '{A_SCTRL,      32'h0, 1'b1};
    vecs[4] = '{32'hF0000018, 32'h0, 1'b0};
    vecs[5] = '{32'hF0000011, 32'h0, 1'b0};
    vecs[6] = '{32'hF0000112, 32'h0, 1'b0};
    vecs[7] = '{32'h00000000, 32'h0, 1'b0};
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < 8; i++) begin
      wrEn = 1'b0;
      addr = vecs[i].addr;
      #1;
      check($sformatf("t1 vec%0d rd", i), rdData, vecs[i].exp_rd);
      check($sformatf("t1 vec%0d hit", i), 32'(addrHit), 32'(vecs[i].exp_hit));
    end
    check("t1 irq", 32'(irq), 32'h0);
    wr(A_KEY, 32'hFFFFFFFF);
    wr(A_SW, 32'hFFFFFFFF);
    read_chk("t1 key after write", A_KEY, 32'h0);
    read_chk("t1 sw after write", A_SW, 32'h0);
    probe("t1");

    // Test 2: KEY[1] press appears exactly D+3 edges later.
    KEY = 4'b1101;
    repeat (6) tick();
    read_chk("t2 key early", A_KEY, 32'h0);
    read_chk("t2 kctrl early", A_KCTRL, 32'h0);
    tick();
    read_chk("t2 key", A_KEY, 32'h2);
    read_chk("t2 kctrl", A_KCTRL, 32'h1);
    wr(A_KCTRL, 32'h0);
    read_chk("t2 kctrl cleared", A_KCTRL, 32'h0);

    // Test 3: a 3-cycle glitch on SW is filtered out.
    SW = 10'h3FF;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) SW = 10'h0;
      tick();
      read_chk($sformatf("t3 sw c%0d", i), A_SW, 32'h0);
      read_chk($sformatf("t3 sctrl c%0d", i), A_SCTRL, 32'h0);
    end

    // Test 4: two events without a clear give ready + overrun.
    SW = 10'h005;
    repeat (10) tick();
    SW = 10'h00A;
    repeat (10) tick();
    read_chk("t4 sw", A_SW, 32'hA);
    read_chk("t4 sctrl", A_SCTRL, 32'h5);
    wr(A_SCTRL, 32'h0);
    read_chk("t4 sctrl cleared", A_SCTRL, 32'h0);

    // Test 5: clearing write in the same cycle as an event.
    KEY = 4'b1001;
    repeat (10) tick();
    read_chk("t5 key", A_KEY, 32'h6);
    read_chk("t5 kctrl ready", A_KCTRL, 32'h1);
    KEY = 4'hF;
    repeat (6) tick();
    wr(A_KCTRL, 32'h0);
    read_chk("t5 kctrl clear+event", A_KCTRL, 32'h1);
    read_chk("t5 key released", A_KEY, 32'h0);
    KEY = 4'b1110;
    repeat (6) tick();
    wr(A_KCTRL, 32'h1);
    read_chk("t5 kctrl ovr-clear+event", A_KCTRL, 32'h5);
    wr(A_KCTRL, 32'h0);
    probe("t5");

    // Reset in the middle of a debounce count aborts it.
    SW = 10'h155;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_chk("rst key", A_KEY, 32'h0);
    read_chk("rst sctrl", A_SCTRL, 32'h0);
    repeat (6) tick();
    read_chk("rst sw early", A_SW, 32'h0);
    read_chk("rst sctrl early", A_SCTRL, 32'h0);
    tick();
    read_chk("rst sw", A_SW, 32'h155);
    read_chk("rst sctrl", A_SCTRL, 32'h1);
    wr(A_SCTRL, 32'h0);
    wr(A_KCTRL, 32'h0);

    // Test 6: interrupt timing and an unmapped neighbour address.
    wr(A_SCTRL, 32'h100);
    read_chk("t6 sctrl ie", A_SCTRL, IRQ_ON ? 32'h100 : 32'h0);
    SW = 10'h0F0;
    repeat (7) tick();
    read_chk("t6 sctrl ready", A_SCTRL, IRQ_ON ? 32'h101 : 32'h1);
    check("t6 irq lag", 32'(irq), 32'h0);
    tick();
    check("t6 irq rise", 32'(irq), 32'(IRQ_ON));
    wr(A_SCTRL, 32'h100);
    read_chk("t6 sctrl cleared", A_SCTRL, IRQ_ON ? 32'h100 : 32'h0);
    check("t6 irq hold", 32'(irq), 32'(IRQ_ON));
    tick();
    check("t6 irq fall", 32'(irq), 32'h0);
    addr = 32'hF0000018;
    #1;
    check("t6 unmapped hit", 32'(addrHit), 32'h0);
    check("t6 unmapped rd", rdData, 32'h0);
    probe("t6");

    // Randomized phase against the reference model.
    for (int c = 0; c < 800; c++) begin
      probe("rnd");
      if (key_hold == 0) begin
        KEY = 4'($urandom);
        key_hold = $urandom_range(1, 10);
      end else key_hold--;
      if (sw_hold == 0) begin
        SW = 10'($urandom);
        sw_hold = $urandom_range(1, 10);
      end else sw_hold--;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 4) == 0) begin
        wrEn = 1'b1;
        case ($urandom_range(0, 4))
          0: addr = A_KCTRL;
          1: addr = A_SCTRL;
          2: addr = A_KEY;
          3: addr = A_SW;
          default: addr = 32'hF0000118;
        endcase
        wrData = $urandom;
      end
      tick();
    end
    reset = 1'b0;
    probe("end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
